axis_video_pattern_gen: RTL



---
 rtl/axis_video_pattern_gen_pkg.sv | 44 ++++
 rtl/axis_video_pattern_gen_if.sv | 14 +
 rtl/axis_video_pattern_gen_pixel.sv | 51 +++++
 rtl/axis_video_pattern_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_video_pattern_gen_pkg.sv
// Shared types and constants for the AXI4-Stream video pattern generator:
// FSM state encoding, pattern codes and colour-bar channel masks.
package axis_video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_BARS  = 2'd2,
    PAT_GRID  = 2'd3
  } pattern_e;

  // Per-channel {R,G,B} on/off bits, in left-to-right bar order
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = BAR_WHITE;
      3'd1:    rgb = BAR_YELLOW;
      3'd2:    rgb = BAR_CYAN;
      3'd3:    rgb = BAR_GREEN;
      3'd4:    rgb = BAR_MAGENTA;
      3'd5:    rgb = BAR_RED;
      3'd6:    rgb = BAR_BLUE;
      default: rgb = BAR_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/axis_video_pattern_gen_if.sv
// AXI4-Stream video bus (tdata/tvalid/tlast/tuser/tready) with master and
// slave views.
interface axis_video_pattern_gen_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_video_pattern_gen_pixel.sv
// Combinational pixel generator: (pattern, x, y, solid colour) -> {R,G,B}.
// Pattern 3 is a grid when AXIS_PATTERN_GRID_EN is defined, otherwise solid.
module axis_pattern_pixel
  import axis_video_pkg::*;
#(
  parameter int WIDTH       = 1920,
  parameter int DATA_WIDTH  = 24,
  parameter int COORD_WIDTH = 16
) (
  input  pattern_e               pattern_i,
  input  logic [COORD_WIDTH-1:0] x_i,
  input  logic [COORD_WIDTH-1:0] y_i,
  input  logic [DATA_WIDTH-1:0]  solid_i,
`ifdef AXIS_PATTERN_GRID_EN
  input  logic                   grid_hit_i,
`endif
  output logic [DATA_WIDTH-1:0]  pixel_o
);

  localparam int C = DATA_WIDTH / 3;

  logic [C-1:0] sum_c;
  logic [2:0]   bar_idx;
  logic [2:0]   rgb;

  // Sum formed one bit wider than the counters, then wrapped to a channel
  assign sum_c = C'({1'b0, x_i} + {1'b0, y_i});

  // Thresholds rise monotonically, so the last one passed is the bar index
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x_i >= COORD_WIDTH'((i * WIDTH) / 8)) bar_idx = 3'(i);
    end
  end

  assign rgb = bar_rgb(bar_idx);

  always_comb begin
    pixel_o = solid_i;
    case (pattern_i)
      PAT_RAMP: pixel_o = {x_i[C-1:0], y_i[C-1:0], sum_c};
      PAT_BARS: pixel_o = {{C{rgb[2]}}, {C{rgb[1]}}, {C{rgb[0]}}};
`ifdef AXIS_PATTERN_GRID_EN
      PAT_GRID: pixel_o = grid_hit_i ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
`endif
      default:  pixel_o = solid_i;
    endcase
  end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream synthetic video source with SOF/EOL framing, backpressure and
// line/frame blanking. Define AXIS_PATTERN_GRID_EN to enable the grid pattern.
module axis_video_pattern_gen
  import axis_video_pkg::*;
#(
  parameter int WIDTH       = 1920,
  parameter int HEIGHT      = 1080,
  parameter int DATA_WIDTH  = 24,
  parameter int COORD_WIDTH = 16,
  parameter int HBLANK      = 0,
  parameter int VBLANK      = 0,
  parameter int GRID        = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [1:0]              pattern_sel,
  input  logic [DATA_WIDTH-1:0]   solid_color,
  axis_video_pattern_gen_if.master m_axis,
  output logic                    frame_done,
  output logic                    busy
);

  localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(HEIGHT - 1);
  localparam int BLANK_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int CNT_W     = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

  if ((DATA_WIDTH % 3) != 0 || (WIDTH >> COORD_WIDTH) != 0 ||
      (HEIGHT >> COORD_WIDTH) != 0 || GRID < 1) begin : g_param_check
    $error("axis_video_pattern_gen: illegal parameter combination");
  end

  state_e                 state_q, state_d;
  logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  pattern_e               pat_q, pat_d;
  logic [DATA_WIDTH-1:0]  solid_q, solid_d;
  logic [DATA_WIDTH-1:0]  pix;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic                   frame_done_q, frame_done_d, busy_q;
  logic                   hs, load, clear, frame_end;

  assign hs = tvalid_q && m_axis.tready;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cnt_d        = cnt_q;
    pat_d        = pat_q;
    solid_d      = solid_q;
    load         = 1'b0;
    clear        = 1'b0;
    frame_end    = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          pat_d   = pattern_e'(pattern_sel);
          solid_d = solid_color;
          x_d     = '0;
          y_d     = '0;
          load    = 1'b1;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (hs) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d          = '0;
              frame_done_d = 1'b1;
              if (VBLANK > 0) begin
                state_d = ST_VBLANK;
                cnt_d   = CNT_W'(VBLANK - 1);
                clear   = 1'b1;
              end else begin
                frame_end = 1'b1;
              end
            end else begin
              y_d = y_q + 1'b1;
              if (HBLANK > 0) begin
                state_d = ST_HBLANK;
                cnt_d   = CNT_W'(HBLANK - 1);
                clear   = 1'b1;
              end else begin
                load = 1'b1;
              end
            end
          end else begin
            x_d  = x_q + 1'b1;
            load = 1'b1;
          end
        end
      end
      ST_HBLANK: begin
        if (cnt_q == '0) begin
          load    = 1'b1;
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_VBLANK: begin
        if (cnt_q == '0) frame_end = 1'b1;
        else             cnt_d     = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // enable is only consulted here and in IDLE; coordinates are already 0
    if (frame_end) begin
      if (enable) begin
        pat_d   = pattern_e'(pattern_sel);
        solid_d = solid_color;
        load    = 1'b1;
        state_d = ST_ACTIVE;
      end else begin
        clear   = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

`ifdef AXIS_PATTERN_GRID_EN
  localparam logic [COORD_WIDTH-1:0] G_LAST = COORD_WIDTH'(GRID - 1);

  logic [COORD_WIDTH-1:0] gx_q, gx_d, gy_q, gy_d;
  logic                   grid_hit;

  // Modulo counters shadow x/y: cleared with the coordinate, stepped with it
  always_comb begin
    gx_d = gx_q;
    gy_d = gy_q;
    if (x_d == '0)        gx_d = '0;
    else if (x_d != x_q)  gx_d = (gx_q == G_LAST) ? '0 : gx_q + 1'b1;
    if (y_d == '0)        gy_d = '0;
    else if (y_d != y_q)  gy_d = (gy_q == G_LAST) ? '0 : gy_q + 1'b1;
  end

  assign grid_hit = (gx_d == '0) || (gy_d == '0) || (x_d == X_LAST) || (y_d == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_q <= '0;
      gy_q <= '0;
    end else begin
      gx_q <= gx_d;
      gy_q <= gy_d;
    end
  end
`endif

  axis_pattern_pixel #(
    .WIDTH      (WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .COORD_WIDTH(COORD_WIDTH)
  ) u_pixel (
    .pattern_i  (pat_d),
    .x_i        (x_d),
    .y_i        (y_d),
    .solid_i    (solid_d),
`ifdef AXIS_PATTERN_GRID_EN
    .grid_hit_i (grid_hit),
`endif
    .pixel_o    (pix)
  );

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = pix;
      tlast_d  = (x_d == X_LAST);
      tuser_d  = (x_d == '0) && (y_d == '0);
    end else if (clear) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tuser_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      pat_q        <= PAT_SOLID;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      pat_q        <= pat_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      frame_done_q <= frame_done_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    solid_q <= solid_d;
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;
  assign frame_done    = frame_done_q;
  assign busy          = busy_q;

endmodule
